vc_meta_lru_array: RTL and testbench

- Parametrised next-generation victim-cache metadata store: VC_SIZE entries of META_W bits each, with per-bit write masks, registered reads with write-first bypass, single-cycle flush, and true-LRU age tracking.
- Produces a victim index for the victim-cache controller: the lowest-index invalid entry if one exists, otherwise the least-recently-used entry.
- Sits beside the victim-cache data array; one instance holds all per-way metadata (valid, dirty, user bits).

---
 rtl/vc_meta_lru_if.sv | 32 +++
 rtl/vc_meta_lru_array.sv | 102 ++++++++++
 tb/tb_vc_meta_lru_array.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vc_meta_lru_if.sv
// Request/response bundle between the victim-cache controller and its metadata/LRU store.
// The controller side is master; the store is slave.
interface vc_meta_lru_if #(
    parameter int unsigned VC_SIZE = 8,
    parameter int unsigned META_W  = 2
);
    localparam int unsigned IDX_W = $clog2(VC_SIZE);

    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [META_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [META_W-1:0] wr_data;
    logic [META_W-1:0] wr_bmask;
    logic              touch_en;
    logic [IDX_W-1:0]  touch_idx;
    logic              inv_all;
    logic [IDX_W-1:0]  victim_idx;
    logic              all_valid;

    modport master (
        output rd_en, rd_idx, wr_en, wr_idx, wr_data, wr_bmask, touch_en, touch_idx, inv_all,
        input  rd_data, rd_valid, victim_idx, all_valid
    );

    modport slave (
        input  rd_en, rd_idx, wr_en, wr_idx, wr_data, wr_bmask, touch_en, touch_idx, inv_all,
        output rd_data, rd_valid, victim_idx, all_valid
    );
endinterface

// File: rtl/vc_meta_lru_array.sv
// Victim-cache metadata store: masked writes, write-first registered reads, flush,
// and true-LRU ages that drive victim selection.
module vc_meta_lru_array #(
    parameter int unsigned VC_SIZE   = 8,
    parameter int unsigned META_W    = 2,
    parameter int unsigned VALID_BIT = 0,
    localparam int unsigned IDX_W    = $clog2(VC_SIZE)
) (
    input logic           clk,
    input logic           rst,
    vc_meta_lru_if.slave  bus
);

    logic [META_W-1:0] meta_q [VC_SIZE];
    logic [META_W-1:0] meta_d [VC_SIZE];
    logic [IDX_W-1:0]  age_q  [VC_SIZE];
    logic [IDX_W-1:0]  age_d  [VC_SIZE];
    logic [META_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic [IDX_W-1:0]  touch_age;
    logic [VC_SIZE-1:0] valid_vec;
    logic [IDX_W-1:0]  invalid_idx;
    logic [IDX_W-1:0]  lru_idx;

    // Flush wins over a same-cycle write; the read port sees this merged next state.
    always_comb begin
        for (int i = 0; i < int'(VC_SIZE); i++) begin
            meta_d[i] = meta_q[i];
            if (bus.inv_all) begin
                meta_d[i] = '0;
            end else if (bus.wr_en && bus.wr_idx == IDX_W'(i)) begin
                meta_d[i] = (meta_q[i] & ~bus.wr_bmask) | (bus.wr_data & bus.wr_bmask);
            end
        end
    end

    // Entries younger than the touched one age by one; the touched one becomes MRU.
    always_comb begin
        touch_age = age_q[bus.touch_idx];
        for (int i = 0; i < int'(VC_SIZE); i++) begin
            age_d[i] = age_q[i];
            if (bus.touch_en) begin
                if (bus.touch_idx == IDX_W'(i)) begin
                    age_d[i] = '0;
                end else if (age_q[i] < touch_age) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(VC_SIZE); i++) begin
                meta_q[i] <= '0;
                age_q[i]  <= IDX_W'(i);
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(VC_SIZE); i++) begin
                meta_q[i] <= meta_d[i];
                age_q[i]  <= age_d[i];
            end
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= meta_d[bus.rd_idx];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(VC_SIZE); i++) begin
            valid_vec[i] = meta_q[i][VALID_BIT];
        end
    end

    // Downward scan so the lowest invalid index is the last assignment.
    always_comb begin
        invalid_idx = '0;
        for (int i = int'(VC_SIZE) - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                invalid_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < int'(VC_SIZE); i++) begin
            if (age_q[i] == IDX_W'(VC_SIZE - 1)) begin
                lru_idx = IDX_W'(i);
            end
        end
    end

    assign bus.all_valid  = &valid_vec;
    assign bus.victim_idx = bus.all_valid ? lru_idx : invalid_idx;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_vc_meta_lru_array.sv
// Scoreboard bench for vc_meta_lru_array: a reference model predicts reads, victims and
// all_valid; expected reads are queued at drive time and popped when the DUT responds.
module tb_vc_meta_lru_array;
    localparam int VC = 8;
    localparam int MW = 2;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vc_meta_lru_if #(.VC_SIZE(VC), .META_W(MW)) bus ();

    vc_meta_lru_array #(.VC_SIZE(VC), .META_W(MW), .VALID_BIT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [MW-1:0] m_meta [VC];
    logic [IW-1:0] m_age  [VC];
    logic          exp_valid;
    logic [MW-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    function automatic logic [IW-1:0] model_victim();
        for (int i = 0; i < VC; i++) if (!m_meta[i][0]) return IW'(i);
        for (int i = 0; i < VC; i++) if (m_age[i] == IW'(VC - 1)) return IW'(i);
        return '0;
    endfunction

    function automatic logic model_all_valid();
        for (int i = 0; i < VC; i++) if (!m_meta[i][0]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle();
        bus.rd_en = 0; bus.rd_idx = 0; bus.wr_en = 0; bus.wr_idx = 0; bus.wr_data = 0;
        bus.wr_bmask = 0; bus.touch_en = 0; bus.touch_idx = 0; bus.inv_all = 0;
    endtask

    // Update the model from the inputs presented at this edge, then let the edge happen.
    task automatic cycle();
        logic [MW-1:0] nm [VC];
        logic [IW-1:0] na [VC];
        logic [IW-1:0] a;
        if (rst) begin
            for (int i = 0; i < VC; i++) begin
                m_meta[i] = '0;
                m_age[i]  = IW'(i);
            end
            exp_valid = 1'b0;
            exp_q.delete();
        end else begin
            for (int i = 0; i < VC; i++) begin
                nm[i] = m_meta[i];
                if (bus.inv_all) nm[i] = '0;
                else if (bus.wr_en && bus.wr_idx == IW'(i))
                    nm[i] = (m_meta[i] & ~bus.wr_bmask) | (bus.wr_data & bus.wr_bmask);
            end
            if (bus.rd_en) exp_q.push_back(nm[bus.rd_idx]);
            exp_valid = bus.rd_en;
            a = m_age[bus.touch_idx];
            for (int j = 0; j < VC; j++) begin
                na[j] = m_age[j];
                if (bus.touch_en) begin
                    if (bus.touch_idx == IW'(j)) na[j] = '0;
                    else if (m_age[j] < a) na[j] = m_age[j] + 1'b1;
                end
            end
            m_meta = nm;
            m_age  = na;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [MW-1:0] e;
        idle();
        rst = 1; cycle(); cycle(); rst = 0;
        cycle();
        total++; if (bus.rd_data !== 2'b00) begin bad++;
            $display("FAIL reset_rd_data got=%0b want=00", bus.rd_data); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++;
            $display("FAIL reset_rd_valid got=%0b want=0", bus.rd_valid); end
        total++; if (bus.victim_idx !== 3'd0) begin bad++;
            $display("FAIL reset_victim got=%0d want=0", bus.victim_idx); end
        total++; if (bus.all_valid !== 1'b0) begin bad++;
            $display("FAIL reset_all_valid got=%0b want=0", bus.all_valid); end
        bus.rd_en = 1; bus.rd_idx = 5; cycle(); idle();
        e = exp_q.pop_front();
        total++; if (bus.rd_valid !== 1'b1) begin bad++;
            $display("FAIL read5_valid got=%0b want=1", bus.rd_valid); end
        total++; if (bus.rd_data !== e || e !== 2'b00) begin bad++;
            $display("FAIL read5_data got=%0b want=00 model=%0b", bus.rd_data, e); end
    endtask

    task automatic test_mask_write();
        logic [MW-1:0] e;
        bus.wr_en = 1; bus.wr_idx = 3; bus.wr_data = 2'b11; bus.wr_bmask = 2'b11; cycle();
        bus.wr_data = 2'b00; bus.wr_bmask = 2'b10; cycle(); idle();
        bus.rd_en = 1; bus.rd_idx = 3; cycle(); idle();
        e = exp_q.pop_front();
        total++; if (bus.rd_data !== e || e !== 2'b01) begin bad++;
            $display("FAIL mask_write got=%0b want=01 model=%0b", bus.rd_data, e); end
    endtask

    task automatic test_bypass();
        logic [MW-1:0] e;
        bus.wr_en = 1; bus.wr_idx = 6; bus.wr_data = 2'b11; bus.wr_bmask = 2'b11;
        bus.rd_en = 1; bus.rd_idx = 6; cycle(); idle();
        e = exp_q.pop_front();
        total++; if (bus.rd_data !== e || e !== 2'b11) begin bad++;
            $display("FAIL bypass_data got=%0b want=11 model=%0b", bus.rd_data, e); end
        bus.wr_en = 1; bus.wr_idx = 6; bus.wr_data = 2'b00; bus.wr_bmask = 2'b11; cycle(); idle();
        total++; if (bus.rd_valid !== 1'b0) begin bad++;
            $display("FAIL idle_rd_valid got=%0b want=0", bus.rd_valid); end
        total++; if (bus.rd_data !== 2'b11) begin bad++;
            $display("FAIL rd_data_hold got=%0b want=11", bus.rd_data); end
    endtask

    task automatic test_fill();
        logic [IW-1:0] ev;
        idle(); rst = 1; cycle(); rst = 0;
        for (int i = 0; i < VC; i++) begin
            bus.wr_en = 1; bus.wr_idx = IW'(i); bus.wr_data = 2'b01; bus.wr_bmask = 2'b01;
            cycle(); idle();
            ev = (i < VC - 1) ? IW'(i + 1) : IW'(VC - 1);
            total++; if (bus.victim_idx !== ev || model_victim() !== ev) begin bad++;
                $display("FAIL fill_victim[%0d] got=%0d want=%0d", i, bus.victim_idx, ev); end
            total++; if (bus.all_valid !== (i == VC - 1)) begin bad++;
                $display("FAIL fill_all_valid[%0d] got=%0b want=%0b", i, bus.all_valid,
                         (i == VC - 1)); end
        end
    endtask

    task automatic test_touch();
        logic [IW-1:0] tidx [4] = '{3'd7, 3'd6, 3'd5, 3'd4};
        logic [IW-1:0] want [4] = '{3'd6, 3'd5, 3'd4, 3'd3};
        for (int k = 0; k < 4; k++) begin
            bus.touch_en = 1; bus.touch_idx = tidx[k]; cycle(); idle();
            if (k == 0) continue;
            total++; if (bus.victim_idx !== want[k] || model_victim() !== want[k]) begin bad++;
                $display("FAIL touch%0d_victim got=%0d want=%0d", tidx[k], bus.victim_idx,
                         want[k]); end
        end
        // Re-touching the MRU entry leaves the order alone.
        bus.touch_en = 1; bus.touch_idx = 3'd4; cycle(); idle();
        total++; if (bus.victim_idx !== 3'd3) begin bad++;
            $display("FAIL touch_mru_victim got=%0d want=3", bus.victim_idx); end
    endtask

    task automatic test_flush();
        logic [MW-1:0] e;
        bus.inv_all = 1; bus.wr_en = 1; bus.wr_idx = 2; bus.wr_data = 2'b11;
        bus.wr_bmask = 2'b11; bus.rd_en = 1; bus.rd_idx = 2; cycle(); idle();
        e = exp_q.pop_front();
        total++; if (bus.rd_data !== e || e !== 2'b00) begin bad++;
            $display("FAIL flush_rd_data got=%0b want=00", bus.rd_data); end
        total++; if (bus.victim_idx !== 3'd0) begin bad++;
            $display("FAIL flush_victim got=%0d want=0", bus.victim_idx); end
        total++; if (bus.all_valid !== 1'b0) begin bad++;
            $display("FAIL flush_all_valid got=%0b want=0", bus.all_valid); end
        for (int i = 0; i < VC; i++) begin
            bus.wr_en = 1; bus.wr_idx = IW'(i); bus.wr_data = 2'b01; bus.wr_bmask = 2'b01;
            cycle();
        end
        idle();
        total++; if (bus.victim_idx !== 3'd3) begin bad++;
            $display("FAIL flush_ages_kept got=%0d want=3", bus.victim_idx); end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] e;
        bus.rd_en = 1; bus.rd_idx = 2; cycle();
        rst = 1; cycle(); rst = 0; idle();
        total++; if (bus.rd_valid !== 1'b0) begin bad++;
            $display("FAIL reset_drops_read got=%0b want=0", bus.rd_valid); end
        if (exp_q.size() != 0 && !exp_valid) exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(59) == 0);
            bus.inv_all  = ($urandom_range(24) == 0);
            bus.rd_en    = $urandom_range(1);
            bus.rd_idx   = IW'($urandom_range(VC - 1));
            bus.wr_en    = ($urandom_range(3) != 0);
            bus.wr_idx   = IW'($urandom_range(VC - 1));
            bus.wr_data  = MW'($urandom_range(3));
            bus.wr_bmask = MW'($urandom_range(3));
            bus.touch_en = $urandom_range(1);
            bus.touch_idx = IW'($urandom_range(VC - 1));
            cycle();
            total++; if (bus.rd_valid !== exp_valid) begin bad++;
                $display("FAIL rand_rd_valid[%0d] got=%0b want=%0b", n, bus.rd_valid,
                         exp_valid); end
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rand_queue_empty[%0d] got=%0b want=none", n, bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    total++; if (bus.rd_data !== e) begin bad++;
                        $display("FAIL rand_rd_data[%0d] got=%0b want=%0b", n, bus.rd_data, e);
                    end
                end
            end
            total++; if (bus.victim_idx !== model_victim()) begin bad++;
                $display("FAIL rand_victim[%0d] got=%0d want=%0d", n, bus.victim_idx,
                         model_victim()); end
            total++; if (bus.all_valid !== model_all_valid()) begin bad++;
                $display("FAIL rand_all_valid[%0d] got=%0b want=%0b", n, bus.all_valid,
                         model_all_valid()); end
        end
        rst = 0; idle();
    endtask

    initial begin
        test_reset();
        test_mask_write();
        test_bypass();
        test_fill();
        test_touch();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
